// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback arbiter slice.
// Holds the port widths, the writeback source encoding and the one-hot register helper.
package rf_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // One-hot mask selecting a single architectural register
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << addr;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: tracks in-flight destinations and raises RAW/WAW hazards.
// A register stays busy through its commit cycle; a same-edge set beats a clear.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  input  logic                  i_issue_wr,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic                  i_clr_en,
  input  logic [REG_ADDR_W-1:0] i_clr_addr,
  output logic                  o_issue_ready,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy
);

  logic [NUM_REGS-1:0] pending_r;
  logic [NUM_REGS-1:0] pending_nxt_s;
  logic [NUM_REGS-1:0] set_mask_s;
  logic [NUM_REGS-1:0] clr_mask_s;
  logic                hazard_s;

  // Busy lookup, hazard detection and issue acceptance
  always_comb begin
    o_rs1_busy    = pending_r[i_rs1_addr];
    o_rs2_busy    = pending_r[i_rs2_addr];
    hazard_s      = o_rs1_busy | o_rs2_busy | (i_issue_wr & pending_r[i_issue_rd]);
    o_issue_ready = i_issue_valid & ~hazard_s & ~i_reset;
  end

  // Next pending vector from the set/clear masks, x0 forced clear
  always_comb begin
    set_mask_s    = {NUM_REGS{1'b0}};
    clr_mask_s    = {NUM_REGS{1'b0}};
    if (o_issue_ready && i_issue_wr && (i_issue_rd != REG_ZERO)) begin
      set_mask_s = reg_onehot(i_issue_rd);
    end else begin
      set_mask_s = {NUM_REGS{1'b0}};
    end
    if (i_clr_en) begin
      clr_mask_s = reg_onehot(i_clr_addr);
    end else begin
      clr_mask_s = {NUM_REGS{1'b0}};
    end
    pending_nxt_s = ((pending_r & ~clr_mask_s) | set_mask_s) & ~reg_onehot(REG_ZERO);
  end

  // Pending vector register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pending_r <= {NUM_REGS{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter (ALU vs LSU) driving the single register-file write port.
// Write outputs are registered one cycle after the grant; the scoreboard clears on that write.
module rf_wb_arbiter
  import rf_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  input  logic                  i_issue_wr,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  output logic                  o_issue_ready,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy,
  input  logic                  i_alu_valid,
  input  logic [REG_ADDR_W-1:0] i_alu_rd,
  input  logic [XLEN-1:0]       i_alu_data,
  output logic                  o_alu_ready,
  input  logic                  i_lsu_valid,
  input  logic [REG_ADDR_W-1:0] i_lsu_rd,
  input  logic [XLEN-1:0]       i_lsu_data,
  output logic                  o_lsu_ready,
  output logic                  o_rd_wren,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic [XLEN-1:0]       o_rd_data
);

  wb_src_e               ptr_r;
  logic                  grant_alu_s;
  logic                  grant_lsu_s;
  logic [REG_ADDR_W-1:0] wb_rd_s;
  logic [XLEN-1:0]       wb_data_s;

  rf_scoreboard u_scoreboard (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .i_issue_wr    (i_issue_wr),
    .i_rs1_addr    (i_rs1_addr),
    .i_rs2_addr    (i_rs2_addr),
    .i_clr_en      (o_rd_wren),
    .i_clr_addr    (o_rd_addr),
    .o_issue_ready (o_issue_ready),
    .o_rs1_busy    (o_rs1_busy),
    .o_rs2_busy    (o_rs2_busy)
  );

  // Grant selection; the pointer only breaks ties, and reset suppresses any grant
  always_comb begin
    grant_alu_s = 1'b0;
    grant_lsu_s = 1'b0;
    if (i_reset) begin
      grant_alu_s = 1'b0;
      grant_lsu_s = 1'b0;
    end else if (i_alu_valid && i_lsu_valid) begin
      grant_alu_s = (ptr_r == WB_SRC_ALU);
      grant_lsu_s = (ptr_r == WB_SRC_LSU);
    end else begin
      grant_alu_s = i_alu_valid;
      grant_lsu_s = i_lsu_valid;
    end
    o_alu_ready = grant_alu_s;
    o_lsu_ready = grant_lsu_s;
  end

  // Writeback payload mux for the granted source
  always_comb begin
    wb_rd_s   = i_alu_rd;
    wb_data_s = i_alu_data;
    if (grant_lsu_s) begin
      wb_rd_s   = i_lsu_rd;
      wb_data_s = i_lsu_data;
    end else begin
      wb_rd_s   = i_alu_rd;
      wb_data_s = i_alu_data;
    end
  end

  // Round-robin pointer and registered write port
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr_r     <= WB_SRC_ALU;
      o_rd_wren <= 1'b0;
      o_rd_addr <= REG_ZERO;
      o_rd_data <= {XLEN{1'b0}};
    end else if (grant_alu_s || grant_lsu_s) begin
      ptr_r     <= grant_alu_s ? WB_SRC_LSU : WB_SRC_ALU;
      o_rd_wren <= (wb_rd_s != REG_ZERO);
      o_rd_addr <= wb_rd_s;
      o_rd_data <= wb_data_s;
    end else begin
      o_rd_wren <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed, table-driven bench for rf_wb_arbiter: per-cycle vectors with hand-computed
// combinational and next-cycle registered expectations, plus reset corner sequences.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic                  i_clk = 1'b0;
  logic                  i_reset;
  logic                  i_issue_valid;
  logic [REG_ADDR_W-1:0] i_issue_rd;
  logic                  i_issue_wr;
  logic [REG_ADDR_W-1:0] i_rs1_addr;
  logic [REG_ADDR_W-1:0] i_rs2_addr;
  logic                  o_issue_ready;
  logic                  o_rs1_busy;
  logic                  o_rs2_busy;
  logic                  i_alu_valid;
  logic [REG_ADDR_W-1:0] i_alu_rd;
  logic [XLEN-1:0]       i_alu_data;
  logic                  o_alu_ready;
  logic                  i_lsu_valid;
  logic [REG_ADDR_W-1:0] i_lsu_rd;
  logic [XLEN-1:0]       i_lsu_data;
  logic                  o_lsu_ready;
  logic                  o_rd_wren;
  logic [REG_ADDR_W-1:0] o_rd_addr;
  logic [XLEN-1:0]       o_rd_data;

  rf_wb_arbiter dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd), .i_issue_wr(i_issue_wr),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .o_issue_ready(o_issue_ready), .o_rs1_busy(o_rs1_busy), .o_rs2_busy(o_rs2_busy),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data), .o_alu_ready(o_alu_ready),
    .i_lsu_valid(i_lsu_valid), .i_lsu_rd(i_lsu_rd), .i_lsu_data(i_lsu_data), .o_lsu_ready(o_lsu_ready),
    .o_rd_wren(o_rd_wren), .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        av;  logic [4:0] ard; logic [31:0] adat;
    logic        lv;  logic [4:0] lrd; logic [31:0] ldat;
    logic        iv;  logic       iwr; logic [4:0]  ird;
    logic [4:0]  rs1; logic [4:0] rs2;
    logic        e_ar; logic e_lr; logic e_ir; logic e_b1; logic e_b2;
    logic        e_w;  logic [4:0] e_a; logic [31:0] e_d;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic [31:0] adat,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
    input logic iv, input logic iwr, input logic [4:0] ird,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic e_ar, input logic e_lr, input logic e_ir, input logic e_b1, input logic e_b2,
    input logic e_w, input logic [4:0] e_a, input logic [31:0] e_d);
    vec_t v;
    v = {av, ard, adat, lv, lrd, ldat, iv, iwr, ird, rs1, rs2,
         e_ar, e_lr, e_ir, e_b1, e_b2, e_w, e_a, e_d};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_alu_valid = 1'b0; i_alu_rd = 5'd0; i_alu_data = 32'd0;
    i_lsu_valid = 1'b0; i_lsu_rd = 5'd0; i_lsu_data = 32'd0;
    i_issue_valid = 1'b0; i_issue_wr = 1'b0; i_issue_rd = 5'd0;
    i_rs1_addr = 5'd0; i_rs2_addr = 5'd0;
  endtask

  task automatic check_all_idle(input string tag);
    for (int a = 0; a < NUM_REGS; a++) begin
      i_rs1_addr = 5'(a);
      i_rs2_addr = 5'(NUM_REGS - 1 - a);
      #1;
      chk($sformatf("%s_rs1_busy[%0d]", tag, a), {31'd0, o_rs1_busy}, 32'd0);
      chk($sformatf("%s_rs2_busy[%0d]", tag, NUM_REGS - 1 - a), {31'd0, o_rs2_busy}, 32'd0);
    end
  endtask

  initial begin
    //             alu            lsu                  issue      rs      exp comb       exp reg
    vecs[0]  = mk(1,5,32'hDEADBEEF, 0,0,32'h0,        0,0,0, 0,0,   1,0,0,0,0, 1,5,32'hDEADBEEF);
    vecs[1]  = mk(0,0,32'h0,        1,9,32'h00000099, 0,0,0, 0,0,   0,1,0,0,0, 1,9,32'h00000099);
    vecs[2]  = mk(1,1,32'h11111111, 1,2,32'h22222222, 0,0,0, 0,0,   1,0,0,0,0, 1,1,32'h11111111);
    vecs[3]  = mk(1,1,32'h11111111, 1,2,32'h22222222, 0,0,0, 0,0,   0,1,0,0,0, 1,2,32'h22222222);
    vecs[4]  = mk(1,1,32'h11111111, 1,2,32'h22222222, 0,0,0, 0,0,   1,0,0,0,0, 1,1,32'h11111111);
    vecs[5]  = mk(1,1,32'h11111111, 1,2,32'h22222222, 0,0,0, 0,0,   0,1,0,0,0, 1,2,32'h22222222);
    vecs[6]  = mk(0,0,32'h0,        0,0,32'h0,        0,0,0, 5,9,   0,0,0,0,0, 0,2,32'h22222222);
    vecs[7]  = mk(1,0,32'h00001234, 0,0,32'h0,        0,0,0, 0,0,   1,0,0,0,0, 0,0,32'h00001234);
    vecs[8]  = mk(0,0,32'h0,        0,0,32'h0,        1,1,7, 0,0,   0,0,1,0,0, 0,0,32'h00001234);
    vecs[9]  = mk(0,0,32'h0,        1,7,32'h77777777, 1,0,0, 7,3,   0,1,0,1,0, 1,7,32'h77777777);
    vecs[10] = mk(0,0,32'h0,        0,0,32'h0,        1,0,0, 7,3,   0,0,0,1,0, 0,7,32'h77777777);
    vecs[11] = mk(0,0,32'h0,        0,0,32'h0,        1,0,0, 7,5,   0,0,1,0,0, 0,7,32'h77777777);
    vecs[12] = mk(1,3,32'h33333333, 0,0,32'h0,        0,0,0, 3,0,   1,0,0,0,0, 1,3,32'h33333333);
    vecs[13] = mk(0,0,32'h0,        0,0,32'h0,        1,1,3, 0,0,   0,0,1,0,0, 0,3,32'h33333333);
    vecs[14] = mk(0,0,32'h0,        0,0,32'h0,        1,0,0, 3,7,   0,0,0,1,0, 0,3,32'h33333333);
    vecs[15] = mk(0,0,32'h0,        0,0,32'h0,        0,0,0, 0,3,   0,0,0,0,1, 0,3,32'h33333333);

    // Reset cycle with every requester active: all readies must be held low
    idle_inputs();
    i_reset = 1'b1;
    i_alu_valid = 1'b1; i_alu_rd = 5'd4; i_alu_data = 32'hA5A5A5A5;
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd6; i_lsu_data = 32'h5A5A5A5A;
    i_issue_valid = 1'b1; i_issue_wr = 1'b1; i_issue_rd = 5'd4;
    #1;
    chk("rst_alu_ready", {31'd0, o_alu_ready}, 32'd0);
    chk("rst_lsu_ready", {31'd0, o_lsu_ready}, 32'd0);
    chk("rst_issue_ready", {31'd0, o_issue_ready}, 32'd0);
    @(posedge i_clk); #1;
    chk("rst_wren", {31'd0, o_rd_wren}, 32'd0);
    chk("rst_addr", {27'd0, o_rd_addr}, 32'd0);
    chk("rst_data", o_rd_data, 32'd0);
    idle_inputs();
    i_reset = 1'b0;
    check_all_idle("rst");
    @(posedge i_clk); #1;
    chk("idle_wren", {31'd0, o_rd_wren}, 32'd0);

    for (int k = 0; k < NV; k++) begin
      i_alu_valid = vecs[k].av;  i_alu_rd = vecs[k].ard;  i_alu_data = vecs[k].adat;
      i_lsu_valid = vecs[k].lv;  i_lsu_rd = vecs[k].lrd;  i_lsu_data = vecs[k].ldat;
      i_issue_valid = vecs[k].iv; i_issue_wr = vecs[k].iwr; i_issue_rd = vecs[k].ird;
      i_rs1_addr = vecs[k].rs1;  i_rs2_addr = vecs[k].rs2;
      #1;
      chk($sformatf("v%0d_alu_ready", k), {31'd0, o_alu_ready}, {31'd0, vecs[k].e_ar});
      chk($sformatf("v%0d_lsu_ready", k), {31'd0, o_lsu_ready}, {31'd0, vecs[k].e_lr});
      chk($sformatf("v%0d_issue_ready", k), {31'd0, o_issue_ready}, {31'd0, vecs[k].e_ir});
      chk($sformatf("v%0d_rs1_busy", k), {31'd0, o_rs1_busy}, {31'd0, vecs[k].e_b1});
      chk($sformatf("v%0d_rs2_busy", k), {31'd0, o_rs2_busy}, {31'd0, vecs[k].e_b2});
      @(posedge i_clk); #1;
      chk($sformatf("v%0d_wren", k), {31'd0, o_rd_wren}, {31'd0, vecs[k].e_w});
      chk($sformatf("v%0d_addr", k), {27'd0, o_rd_addr}, {27'd0, vecs[k].e_a});
      chk($sformatf("v%0d_data", k), o_rd_data, vecs[k].e_d);
    end

    // x3 is still pending here; reset with the LSU requesting must drop the grant and the scoreboard
    idle_inputs();
    i_rs1_addr = 5'd3;
    #1;
    chk("pre_rst_x3_busy", {31'd0, o_rs1_busy}, 32'd1);
    i_reset = 1'b1;
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd10; i_lsu_data = 32'h0000AAAA;
    #1;
    chk("mid_rst_lsu_ready", {31'd0, o_lsu_ready}, 32'd0);
    chk("mid_rst_alu_ready", {31'd0, o_alu_ready}, 32'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    i_lsu_valid = 1'b0;
    chk("post_rst_wren", {31'd0, o_rd_wren}, 32'd0);
    chk("post_rst_addr", {27'd0, o_rd_addr}, 32'd0);
    chk("post_rst_data", o_rd_data, 32'd0);
    @(posedge i_clk); #1;
    chk("post_rst_wren2", {31'd0, o_rd_wren}, 32'd0);
    check_all_idle("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Sequences all writes into the 32x32 register file's single write port, and arbitrates between two writeback sources: ALU (source 0) and LSU (source 1).
- Keeps a pending-write scoreboard. It flags RAW and WAW hazards to issue logic so the core stalls until the producing write has committed.
- Sits between execute/memory writeback and the register file. Its registered write outputs drive the register file write address, write data and write enable directly.

Parameters:
- XLEN, 32, data width of the write port.
- REG_ADDR_W, 5, register address width.
- NUM_REGS, 32, number of architectural registers; x0 is hardwired zero.

Ports:
- i_clk  in  1  clock, posedge.
- i_reset  in  1  synchronous, active-high reset.
- i_issue_valid  in  1  issue stage presents an instruction.
- i_issue_rd  in  REG_ADDR_W  destination of the issuing instruction.
- i_issue_wr  in  1  issuing instruction writes rd.
- i_rs1_addr  in  REG_ADDR_W  source 1 of the issuing instruction.
- i_rs2_addr  in  REG_ADDR_W  source 2 of the issuing instruction.
- o_issue_ready  out  1  issue accepted this cycle (no hazard).
- o_rs1_busy  out  1  rs1 has a pending write.
- o_rs2_busy  out  1  rs2 has a pending write.
- i_alu_valid  in  1  ALU writeback request.
- i_alu_rd  in  REG_ADDR_W  ALU destination.
- i_alu_data  in  XLEN  ALU result.
- o_alu_ready  out  1  ALU request granted.
- i_lsu_valid  in  1  LSU writeback request.
- i_lsu_rd  in  REG_ADDR_W  LSU destination.
- i_lsu_data  in  XLEN  load data.
- o_lsu_ready  out  1  LSU request granted.
- o_rd_wren  out  1  write enable to the register file.
- o_rd_addr  out  REG_ADDR_W  write address.
- o_rd_data  out  XLEN  write data.

Behaviour:
- Reset:
  - All scoreboard bits cleared.
  - Priority pointer set to ALU.
  - o_rd_wren=0, o_rd_addr=0, o_rd_data=0.
  - During the reset cycle, o_alu_ready, o_lsu_ready and o_issue_ready are forced to 0.
  - Reset mid-transfer discards any grant in that cycle; no write is produced afterwards.
- Handshake:
  - A request transfers on the cycle valid&&ready is high.
  - The requester must hold valid, rd and data stable until ready.
  - Ready is combinational from the valids and the pointer. It never depends on the same source's ready.
- Arbitration, round-robin over two sources:
  - Exactly one grant per cycle when at least one source is valid.
  - Only one valid source: that source is granted.
  - Both valid: the source named by the pointer is granted.
  - After any grant, the pointer moves to the other source. With no grant, the pointer holds.
  - Neither source waits more than one cycle while the other is continuously valid.
- Write output (1-cycle latency, registered):
  - Cycle after a transfer: o_rd_addr and o_rd_data take the granted rd and data.
  - o_rd_wren=1 only if rd!=0.
  - Cycle with no transfer: o_rd_wren=0; addr and data hold.
  - A transfer with rd=0 completes its handshake but produces no write.
- Scoreboard (NUM_REGS bits; bit 0 is constant 0):
  - o_rs1_busy = pending[rs1]; o_rs2_busy = pending[rs2]. Both are combinational; x0 is never busy.
  - Hazard = rs1_busy | rs2_busy | (i_issue_wr && pending[i_issue_rd]).
  - o_issue_ready = i_issue_valid && !hazard && !i_reset.
  - Set: pending[i_issue_rd] set on accepted issue when i_issue_wr=1 and i_issue_rd!=0.
  - Clear: pending[o_rd_addr] cleared on the edge ending a cycle with o_rd_wren=1, i.e. when the register file write lands.
  - A register stays busy during its commit cycle. A dependent instruction issues the cycle after the commit; this relies on the register file's combinational read.
  - Same register set and cleared on the same edge: set wins.
  - Writeback to a register that is not pending is legal and causes no scoreboard change. It is flagged by an assertion in the bench, not in RTL.
- No internal buffering; the arbiter never drops an accepted transfer.

Decomposition:
- Shared package rf_pkg:
  - constants XLEN, REG_ADDR_W, NUM_REGS;
  - enum wb_src_e {WB_SRC_ALU=0, WB_SRC_LSU=1};
  - constant REG_ZERO=0.
- One natural sub-module: rf_scoreboard, which owns the pending vector, the set/clear rules and the busy/hazard outputs.
- The arbiter, pointer and output registers stay in rf_wb_arbiter.

Test Plan:
- Reset then idle → all readies 0 in the reset cycle; o_rd_wren=0; rs busy=0 for every address.
- ALU alone valid with rd=5, data=0xDEADBEEF → o_alu_ready=1 same cycle; next cycle o_rd_wren=1, addr=5, data=0xDEADBEEF.
- Both valid for 4 cycles (ALU rd=1, LSU rd=2) → grants alternate ALU, LSU, ALU, LSU; write outputs follow one cycle later in the same order.
- Issue rd=7, i_issue_wr=1 → pending[7]=1:
  - next issue with rs1=7 → o_rs1_busy=1, o_issue_ready=0;
  - after LSU writes rd=7 → busy still 1 in the commit cycle, 0 the cycle after, and issue accepted.
- ALU valid with rd=0, data=0x1234 → ready=1; next cycle o_rd_wren=0; scoreboard unchanged.
- Issue rd=3 on the same edge that commits the earlier write to x3 → pending[3] remains 1. Assert i_reset while LSU is valid → no write the following cycle; all pending bits 0.
